// File: rtl/base_emux_pkg.sv
// Shared definitions for the pipelined wide mux: padded select sizing and the
// per-stage control bundle that travels alongside the candidate words.
package base_emux_pkg;

   localparam int CTL_SEL_W = 32;
   localparam int CTL_AUX_W = 32;

   typedef struct packed {
      logic                 v;
      logic [CTL_SEL_W-1:0] sel;
      logic [CTL_AUX_W-1:0] aux;
   } ctl_t;

   function automatic int esel_width_f(input int sel_w, input int lsel_w);
      return ((sel_w + lsel_w - 1) / lsel_w) * lsel_w;
   endfunction

   function automatic int stages_f(input int sel_w, input int lsel_w);
      return esel_width_f(sel_w, lsel_w) / lsel_w;
   endfunction

endpackage

// File: rtl/base_emux_pipe_stage.sv
// One handshaked mux stage: reduces n_in candidates by 2^lsel_width using the
// lowest remaining select field, then registers survivors and control.
module base_emux_pipe_stage
   import base_emux_pkg::*;
#(
   parameter int width      = 8,
   parameter int lsel_width = 1,
   parameter int n_in       = 2
) (
   input  logic                                    clk_i,
   input  logic                                    reset_i,
   input  logic                                    ld_i,
   input  ctl_t                                    ctl_i,
   input  logic [n_in*width-1:0]                   cand_i,
   output ctl_t                                    ctl_o,
   output logic [(n_in >> lsel_width)*width-1:0]   cand_o
);

   localparam int GRP   = 1 << lsel_width;
   localparam int N_OUT = n_in / GRP;

   logic [lsel_width-1:0]  fld;
   ctl_t                   ctl_d, ctl_q;
   logic [N_OUT*width-1:0] cand_d, cand_q;

   always_comb begin
      fld       = ctl_i.sel[lsel_width-1:0];
      ctl_d     = ctl_i;
      ctl_d.sel = ctl_i.sel >> lsel_width;
      cand_d    = '0;
      for (int g = 0; g < N_OUT; g++)
         cand_d[g*width +: width] = cand_i[(g*GRP + int'(fld))*width +: width];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ctl_q  <= '0;
         cand_q <= '0;
      end else if (ld_i) begin
         ctl_q  <= ctl_d;
         cand_q <= cand_d;
      end
   end

   assign ctl_o  = ctl_q;
   assign cand_o = cand_q;

endmodule

// File: rtl/base_emux_pipe_vr.sv
// Pipelined wide mux with valid/ready flow control and aux sideband.
// Optional macro BASE_EMUX_SEL_CHECK_EN builds the sticky out-of-range flag o_err.
module base_emux_pipe_vr
   import base_emux_pkg::*;
#(
   parameter int width      = 8,
   parameter int ways       = 5,
   parameter int sel_width  = $clog2(ways),
   parameter int lsel_width = 1,
   parameter int aux_width  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_v,
   output logic                   i_r,
   input  logic [0:sel_width-1]   i_sel,
   input  logic [0:width*ways-1]  i_d,
   input  logic [aux_width-1:0]   i_a,
   output logic                   o_v,
   input  logic                   o_r,
   output logic [0:width-1]       o_d,
   output logic [aux_width-1:0]   o_a,
   output logic                   o_err
);

   localparam int ESEL_W = esel_width_f(sel_width, lsel_width);
   localparam int S      = stages_f(sel_width, lsel_width);
   localparam int NPAD   = 1 << ESEL_W;

   logic [NPAD*width-1:0] data_pad;
   ctl_t                  ctl_in;
   logic [S:0]            stg_adv;
   logic [S-1:0]          stg_v;
   logic                  unused_ctl;

   // Unused select codes map onto zero words, so out-of-range selects yield 0.
   always_comb begin
      data_pad = '0;
      for (int k = 0; k < ways; k++)
         data_pad[k*width +: width] = i_d[k*width +: width];
   end

   always_comb begin
      ctl_in     = '0;
      ctl_in.v   = i_v;
      ctl_in.sel = CTL_SEL_W'(i_sel);
      ctl_in.aux = CTL_AUX_W'(i_a);
   end

   always_comb begin
      stg_adv    = '0;
      stg_adv[S] = o_r;
      for (int s = S - 1; s >= 0; s--)
         stg_adv[s] = !stg_v[s] || stg_adv[s+1];
   end

   assign i_r = stg_adv[0] && !reset;

   for (genvar s = 0; s < S; s++) begin : g_stg
      localparam int NIN = NPAD >> (s * lsel_width);
      logic [NIN*width-1:0]                  cand_in;
      logic [(NIN >> lsel_width)*width-1:0]  cand_out;
      ctl_t                                  ctl_si, ctl_so;

      if (s == 0) begin : g_head
         assign cand_in = data_pad;
         assign ctl_si  = ctl_in;
      end else begin : g_chain
         assign cand_in = g_stg[s-1].cand_out;
         assign ctl_si  = g_stg[s-1].ctl_so;
      end

      base_emux_pipe_stage #(
         .width      (width),
         .lsel_width (lsel_width),
         .n_in       (NIN)
      ) u_stage (
         .clk_i   (clk),
         .reset_i (reset),
         .ld_i    (stg_adv[s]),
         .ctl_i   (ctl_si),
         .cand_i  (cand_in),
         .ctl_o   (ctl_so),
         .cand_o  (cand_out)
      );

      assign stg_v[s] = ctl_so.v;
   end

   assign o_v        = g_stg[S-1].ctl_so.v;
   assign o_d        = g_stg[S-1].cand_out;
   assign o_a        = g_stg[S-1].ctl_so.aux[aux_width-1:0];
   assign unused_ctl = ^g_stg[S-1].ctl_so;

`ifdef BASE_EMUX_SEL_CHECK_EN
   logic err_d, err_q;

   always_comb begin
      err_d = err_q;
      if (i_v && i_r && (32'(i_sel) >= 32'(ways)))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign o_err = err_q;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_base_emux_pipe_vr.sv
// Directed bench for base_emux_pipe_vr: a 3-stage instance (ways=5, lsel=1)
// and a single-stage instance (ways=2, lsel=3).
module tb_base_emux_pipe_vr;

`ifdef BASE_EMUX_SEL_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        a_iv, a_ir, a_ov, a_or, a_err;
   logic [0:2]  a_sel;
   logic [0:39] a_d;
   logic [3:0]  a_ia, a_oa;
   logic [0:7]  a_od;

   logic        b_iv, b_ir, b_ov, b_or, b_err;
   logic [0:0]  b_sel;
   logic [0:15] b_d;
   logic [3:0]  b_ia, b_oa;
   logic [0:7]  b_od;

   int checks = 0;
   int errors = 0;

   base_emux_pipe_vr #(.width(8), .ways(5), .lsel_width(1), .aux_width(4)) dut_a (
      .clk(clk), .reset(reset), .i_v(a_iv), .i_r(a_ir), .i_sel(a_sel), .i_d(a_d),
      .i_a(a_ia), .o_v(a_ov), .o_r(a_or), .o_d(a_od), .o_a(a_oa), .o_err(a_err)
   );

   base_emux_pipe_vr #(.width(8), .ways(2), .lsel_width(3), .aux_width(4)) dut_b (
      .clk(clk), .reset(reset), .i_v(b_iv), .i_r(b_ir), .i_sel(b_sel), .i_d(b_d),
      .i_a(b_ia), .o_v(b_ov), .o_r(b_or), .o_d(b_od), .o_a(b_oa), .o_err(b_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words_a(input logic [7:0] base);
      for (int k = 0; k < 5; k++) a_d[k*8 +: 8] = base + 8'(k);
   endtask

   task automatic test_reset();
      reset = 1'b1; a_iv = 1'b1; a_sel = 3'd0; a_ia = 4'h0; a_or = 1'b1;
      set_words_a(8'h10);
      b_iv = 1'b1; b_sel = 1'b0; b_d = 16'h0; b_ia = 4'h0; b_or = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_ov got %0b want 0", a_ov); end
         checks++; if (a_od !== 8'h00) begin errors++; $display("FAIL reset_od got %h want 00", a_od); end
         checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL reset_ir got %0b want 0", a_ir); end
      end
      a_iv = 1'b0; b_iv = 1'b0; reset = 1'b0;
      #1;
      checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL post_reset_ir got %0b want 1", a_ir); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL post_reset_ov got %0b want 0", a_ov); end
      checks++; if (a_oa !== 4'h0) begin errors++; $display("FAIL post_reset_oa got %h want 0", a_oa); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL post_reset_err got %0b want 0", a_err); end
      checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL post_reset_b_ir got %0b want 1", b_ir); end
   endtask

   task automatic test_streaming();
      logic exp_v;
      a_or = 1'b1;
      set_words_a(8'h10);
      for (int c = 0; c < 9; c++) begin
         exp_v = (c >= 3 && c <= 7);
         checks++; if (a_ov !== exp_v) begin errors++; $display("FAIL stream_ov cyc %0d got %0b want %0b", c, a_ov, exp_v); end
         if (exp_v) begin
            checks++; if (a_od !== 8'h10 + 8'(c - 3)) begin errors++; $display("FAIL stream_od cyc %0d got %h want %h", c, a_od, 8'h10 + 8'(c - 3)); end
            checks++; if (a_oa !== 4'(c - 3)) begin errors++; $display("FAIL stream_oa cyc %0d got %h want %h", c, a_oa, 4'(c - 3)); end
         end
         checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL stream_ir cyc %0d got %0b want 1", c, a_ir); end
         if (c < 5) begin
            a_iv = 1'b1; a_sel = 3'(c); a_ia = 4'(c);
         end else begin
            a_iv = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] exp_q[$];
      logic [11:0] exp_item;
      logic [7:0]  held_d;
      logic        held;
      int sent, got;
      sent = 0; got = 0; held = 1'b0; held_d = 8'h00;
      a_sel = 3'd2;
      for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
         a_or = (cyc < 4 || cyc >= 8);
         a_iv = (sent < 10);
         for (int k = 0; k < 5; k++) a_d[k*8 +: 8] = 8'hE0 + 8'(k);
         a_d[16 +: 8] = 8'h20 + 8'(sent);
         a_ia = 4'(sent);
         #1;
         if (cyc == 4) begin
            checks++; if (a_ir !== 1'b0) begin errors++; $display("FAIL bp_ir_fall got %0b want 0", a_ir); end
         end
         if (cyc == 8) begin
            checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL bp_ir_release got %0b want 1", a_ir); end
         end
         if (a_ov && !a_or) begin
            if (held) begin
               checks++; if (a_od !== held_d) begin errors++; $display("FAIL bp_hold_od got %h want %h", a_od, held_d); end
            end
            held = 1'b1; held_d = a_od;
         end else begin
            held = 1'b0;
         end
         if (a_ov && a_or) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL bp_extra_beat got %h want none", a_od);
            end else begin
               exp_item = exp_q.pop_front();
               if ({a_od, a_oa} !== exp_item) begin errors++; $display("FAIL bp_order got %h want %h", {a_od, a_oa}, exp_item); end
            end
            got++;
         end
         if (a_iv && a_ir) begin
            exp_q.push_back({8'h20 + 8'(sent), 4'(sent)});
            sent++;
         end
         tick();
      end
      a_iv = 1'b0; a_or = 1'b1;
      checks++; if (got !== 10) begin errors++; $display("FAIL bp_delivered got %0d want 10", got); end
      tick(); tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL bp_drained_ov got %0b want 0", a_ov); end
      checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_out_of_range();
      a_or = 1'b1;
      set_words_a(8'h30);
      a_sel = 3'd6; a_ia = 4'hA; a_iv = 1'b1;
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL oor_err_before got %0b want 0", a_err); end
      tick();
      a_iv = 1'b0;
      checks++; if (a_err !== ERR_EN) begin errors++; $display("FAIL oor_err_next got %0b want %0b", a_err, ERR_EN); end
      tick(); tick();
      checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL oor_ov got %0b want 1", a_ov); end
      checks++; if (a_od !== 8'h00) begin errors++; $display("FAIL oor_od got %h want 00", a_od); end
      checks++; if (a_oa !== 4'hA) begin errors++; $display("FAIL oor_oa got %h want a", a_oa); end
      tick(); tick();
      checks++; if (a_err !== ERR_EN) begin errors++; $display("FAIL oor_err_sticky got %0b want %0b", a_err, ERR_EN); end
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL oor_ov_after got %0b want 0", a_ov); end
   endtask

   task automatic test_midflight_reset();
      a_or = 1'b1;
      set_words_a(8'h40);
      a_iv = 1'b1; a_sel = 3'd0; a_ia = 4'h1;
      tick();
      a_sel = 3'd1; a_ia = 4'h2;
      tick();
      a_iv = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mid_err_cleared got %0b want 0", a_err); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_no_ov cyc %0d got %0b want 0", i, a_ov); end
         tick();
      end
      a_iv = 1'b1; a_sel = 3'd1; a_ia = 4'h5;
      tick();
      a_iv = 1'b0;
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_lat1 got %0b want 0", a_ov); end
      tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_lat2 got %0b want 0", a_ov); end
      tick();
      checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL mid_lat3_ov got %0b want 1", a_ov); end
      checks++; if (a_od !== 8'h41) begin errors++; $display("FAIL mid_od got %h want 41", a_od); end
      checks++; if (a_oa !== 4'h5) begin errors++; $display("FAIL mid_oa got %h want 5", a_oa); end
      tick();
      checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL mid_ov_after got %0b want 0", a_ov); end
   endtask

   task automatic test_single_stage();
      b_or = 1'b1;
      b_d[0 +: 8] = 8'h5A; b_d[8 +: 8] = 8'hA5;
      b_sel = 1'b0; b_ia = 4'h3; b_iv = 1'b1;
      #1;
      checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL single_ir got %0b want 1", b_ir); end
      tick();
      checks++; if (b_ov !== 1'b1) begin errors++; $display("FAIL single_ov0 got %0b want 1", b_ov); end
      checks++; if (b_od !== 8'h5A) begin errors++; $display("FAIL single_od0 got %h want 5a", b_od); end
      checks++; if (b_oa !== 4'h3) begin errors++; $display("FAIL single_oa0 got %h want 3", b_oa); end
      b_sel = 1'b1; b_ia = 4'h4;
      tick();
      b_iv = 1'b0;
      checks++; if (b_od !== 8'hA5) begin errors++; $display("FAIL single_od1 got %h want a5", b_od); end
      checks++; if (b_oa !== 4'h4) begin errors++; $display("FAIL single_oa1 got %h want 4", b_oa); end
      tick();
      checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL single_ov_end got %0b want 0", b_ov); end
      checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL single_err got %0b want 0", b_err); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_back_to_back();
      test_out_of_range();
      test_midflight_reset();
      test_single_stage();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
